// File: rtl/recursion_mux_fxp_if.sv
// Purpose: groups the sample-in / result-out signals of recursion_mux_fxp.
// Ports:   in_valid/in_ready handshake with x, preload and next-channel tag;
//          out_valid strobe with channel, last flag and complex result y.
interface recursion_mux_fxp_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  inR;
    logic signed [W-1:0]  inI;
    logic                 load;
    logic signed [W-1:0]  loadR;
    logic signed [W-1:0]  loadI;
    logic [CW-1:0]        in_ch;
    logic                 out_valid;
    logic [CW-1:0]        out_ch;
    logic                 out_last;
    logic signed [W-1:0]  outR;
    logic signed [W-1:0]  outI;

    // Sample source / result sink side.
    modport master (
        output in_valid, inR, inI, load, loadR, loadI,
        input  in_ready, in_ch, out_valid, out_ch, out_last, outR, outI
    );

    // Recursion engine side.
    modport slave (
        input  in_valid, inR, inI, load, loadR, loadI,
        output in_ready, in_ch, out_valid, out_ch, out_last, outR, outI
    );
endinterface

// File: rtl/recursion_mux_fxp.sv
// Purpose: N-channel complex recursion y[k] = x[k] + L*y[k-1] on one shared multiplier/adder.
// Latency: 2 cycles from accept to out_valid; 1 sample/cycle for N>=2, 1/2 for N=1.
// Backpressure: in_ready drops on clear or a same-channel hazard in stage 1; output has none.
// Ports: clk, rst (async active-low), clear (sync), bus (slave modport: input handshake,
//        x/preload, in_ch tag; out_valid/out_ch/out_last/outR/outI result strobe).
module recursion_mux_fxp #(
    parameter int N      = 4,
    parameter int n_int  = 8,
    parameter int n_mant = 23,
    parameter logic [N*(n_int+n_mant+1)-1:0] FACT_R = '0,
    parameter logic [N*(n_int+n_mant+1)-1:0] FACT_I = '0,
    parameter bit SAT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    recursion_mux_fxp_if.slave bus
);
    localparam int W  = n_int + n_mant + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * W + 1;   // wide enough for a full complex product sum

    typedef logic signed [W-1:0] word_t;

    // Narrow a wide signed value to W bits: clamp when SAT, otherwise drop the top bits.
    function automatic word_t fit(input logic signed [PW-1:0] v);
        logic [PW-W:0] top;
        top = v[PW-1:W-1];
        if (!SAT || top == {(PW-W+1){v[PW-1]}})
            fit = v[W-1:0];
        else if (v[PW-1])
            fit = {1'b1, {(W-1){1'b0}}};
        else
            fit = {1'b0, {(W-1){1'b1}}};
    endfunction

    word_t st_r [N];
    word_t st_i [N];

    logic [CW-1:0] in_ch_q;
    logic          s1_vld;
    logic [CW-1:0] s1_ch;
    word_t         s1_xr, s1_xi, s1_pr, s1_pi;

    logic          out_vld_q, out_last_q;
    logic [CW-1:0] out_ch_q;
    word_t         out_r_q, out_i_q;

    logic          hazard, accept;
    word_t         s_r, s_i, f_r, f_i, p_r, p_i, y_r, y_i;
    logic signed [2*W-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0]  acc_r, acc_i;
    logic signed [W:0]     sum_r, sum_i;

    // Only possible for N=1: the state being read is still in flight.
    assign hazard       = s1_vld && (s1_ch == in_ch_q);
    assign bus.in_ready = !clear && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: pick the previous output (or preload) and scale it by the channel pole.
    always_comb begin
        s_r   = bus.load ? bus.loadR : st_r[in_ch_q];
        s_i   = bus.load ? bus.loadI : st_i[in_ch_q];
        f_r   = FACT_R[in_ch_q*W +: W];
        f_i   = FACT_I[in_ch_q*W +: W];
        m_rr  = s_r * f_r;
        m_ii  = s_i * f_i;
        m_ri  = s_r * f_i;
        m_ir  = s_i * f_r;
        acc_r = {m_rr[2*W-1], m_rr} - {m_ii[2*W-1], m_ii};
        acc_i = {m_ri[2*W-1], m_ri} + {m_ir[2*W-1], m_ir};
        // Arithmetic shift floors toward minus infinity (-1 * 0.5 stays -1).
        p_r   = fit(acc_r >>> n_mant);
        p_i   = fit(acc_i >>> n_mant);
    end

    // Stage 2: add the new sample one bit wider, then narrow.
    always_comb begin
        sum_r = {s1_xr[W-1], s1_xr} + {s1_pr[W-1], s1_pr};
        sum_i = {s1_xi[W-1], s1_xi} + {s1_pi[W-1], s1_pi};
        y_r   = fit({{(PW-W-1){sum_r[W]}}, sum_r});
        y_i   = fit({{(PW-W-1){sum_i[W]}}, sum_i});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                st_r[i] <= '0;
                st_i[i] <= '0;
            end
            in_ch_q    <= '0;
            s1_vld     <= 1'b0;
            s1_ch      <= '0;
            s1_xr      <= '0;
            s1_xi      <= '0;
            s1_pr      <= '0;
            s1_pi      <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_ch_q   <= '0;
            out_r_q    <= '0;
            out_i_q    <= '0;
        end else if (clear) begin
            // In-flight samples are dropped; the last result stays on outR/outI.
            for (int i = 0; i < N; i++) begin
                st_r[i] <= '0;
                st_i[i] <= '0;
            end
            in_ch_q    <= '0;
            s1_vld     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_ch   <= in_ch_q;
                s1_xr   <= bus.inR;
                s1_xi   <= bus.inI;
                s1_pr   <= p_r;
                s1_pi   <= p_i;
                in_ch_q <= (in_ch_q == CW'(N-1)) ? '0 : in_ch_q + 1'b1;
            end
            out_vld_q  <= s1_vld;
            out_last_q <= s1_vld && (s1_ch == CW'(N-1));
            if (s1_vld) begin
                out_ch_q     <= s1_ch;
                out_r_q      <= y_r;
                out_i_q      <= y_i;
                st_r[s1_ch]  <= y_r;
                st_i[s1_ch]  <= y_i;
            end
        end
    end

    assign bus.in_ch     = in_ch_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.outR      = out_r_q;
    assign bus.outI      = out_i_q;
endmodule

// File: tb/tb_recursion_mux_fxp.sv
// Directed bench for recursion_mux_fxp using four instances (8-bit words, 4 fractional bits):
//   a: N=2, poles 0.5 and j, saturating   b: N=1, pole 0.5
//   c: N=2, pole 1.0, saturating          d: N=2, pole 1.0, wrapping
module tb_recursion_mux_fxp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_a = 1'b0;
    logic clr_0 = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    recursion_mux_fxp_if #(.N(2), .W(8)) ifa ();
    recursion_mux_fxp_if #(.N(1), .W(8)) ifb ();
    recursion_mux_fxp_if #(.N(2), .W(8)) ifc ();
    recursion_mux_fxp_if #(.N(2), .W(8)) ifd ();

    recursion_mux_fxp #(.N(2), .n_int(3), .n_mant(4), .FACT_R(16'h0008), .FACT_I(16'h1000), .SAT(1'b1))
        dut_a (.clk(clk), .rst(rst), .clear(clr_a), .bus(ifa));
    recursion_mux_fxp #(.N(1), .n_int(3), .n_mant(4), .FACT_R(8'h08), .FACT_I(8'h00), .SAT(1'b1))
        dut_b (.clk(clk), .rst(rst), .clear(clr_0), .bus(ifb));
    recursion_mux_fxp #(.N(2), .n_int(3), .n_mant(4), .FACT_R(16'h1010), .FACT_I(16'h0000), .SAT(1'b1))
        dut_c (.clk(clk), .rst(rst), .clear(clr_0), .bus(ifc));
    recursion_mux_fxp #(.N(2), .n_int(3), .n_mant(4), .FACT_R(16'h1010), .FACT_I(16'h0000), .SAT(1'b0))
        dut_d (.clk(clk), .rst(rst), .clear(clr_0), .bus(ifd));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated sample on instance a: accept, then one more edge for the result.
    task automatic send_a(input logic signed [7:0] xr, input logic signed [7:0] xi,
                          input logic ld, input logic signed [7:0] lr, input logic signed [7:0] li);
        ifa.in_valid = 1'b1;
        ifa.inR = xr;
        ifa.inI = xi;
        ifa.load = ld;
        ifa.loadR = lr;
        ifa.loadI = li;
        cyc();
        ifa.in_valid = 1'b0;
        ifa.load = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp0 [6];
        int exp1r [6];
        int exp1i [6];
        int tblb [3];
        int expd [4];

        exp0  = '{16, 8, 4, 2, 1, 0};
        exp1r = '{16, 0, -16, 0, 16, 0};
        exp1i = '{0, 16, 0, -16, 0, 16};
        tblb  = '{4, 6, 7};
        expd  = '{127, 127, -2, -2};

        ifa.in_valid = 1'b0; ifa.inR = '0; ifa.inI = '0; ifa.load = 1'b0; ifa.loadR = '0; ifa.loadI = '0;
        ifb.in_valid = 1'b0; ifb.inR = '0; ifb.inI = '0; ifb.load = 1'b0; ifb.loadR = '0; ifb.loadI = '0;
        ifc.in_valid = 1'b0; ifc.inR = '0; ifc.inI = '0; ifc.load = 1'b0; ifc.loadR = '0; ifc.loadI = '0;
        ifd.in_valid = 1'b0; ifd.inR = '0; ifd.inI = '0; ifd.load = 1'b0; ifd.loadR = '0; ifd.loadI = '0;

        // 1. Reset, then idle.
        cyc(); cyc(); cyc();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("rst_out_valid", ifa.out_valid, 0);
            chk("rst_in_ready", ifa.in_ready, 1);
            chk("rst_in_ch", ifa.in_ch, 0);
            chk("rst_outR", ifa.outR, 0);
            chk("rst_outI", ifa.outI, 0);
            cyc();
        end

        // 2. Interleaved impulse response: ch0 pole 0.5, ch1 pole j.
        for (int k = 0; k < 13; k++) begin
            if (k < 12) begin
                ifa.in_valid = 1'b1;
                ifa.inR = (k < 2) ? 8'sd16 : 8'sd0;
                ifa.inI = 8'sd0;
                chk("imp_in_ready", ifa.in_ready, 1);
                chk("imp_in_ch", ifa.in_ch, k % 2);
            end else begin
                ifa.in_valid = 1'b0;
            end
            cyc();
            if (k >= 1) begin
                chk("imp_out_valid", ifa.out_valid, 1);
                chk("imp_out_ch", ifa.out_ch, (k - 1) % 2);
                chk("imp_out_last", ifa.out_last, (k - 1) % 2);
                if ((k - 1) % 2 == 0) begin
                    chk("imp_ch0_outR", ifa.outR, exp0[(k - 1) / 2]);
                    chk("imp_ch0_outI", ifa.outI, 0);
                end else begin
                    chk("imp_ch1_outR", ifa.outR, exp1r[(k - 1) / 2]);
                    chk("imp_ch1_outI", ifa.outI, exp1i[(k - 1) / 2]);
                end
            end
        end
        cyc();
        chk("imp_idle_valid", ifa.out_valid, 0);

        // 3. Single channel: hazard stalls every other cycle.
        ifb.in_valid = 1'b1;
        ifb.inR = 8'sd4;
        for (int c = 0; c < 8; c++) begin
            chk("n1_in_ready", ifb.in_ready, (c % 2 == 0) ? 1 : 0);
            chk("n1_out_valid", ifb.out_valid, (c >= 2 && c % 2 == 0) ? 1 : 0);
            if (c >= 2 && c % 2 == 0)
                chk("n1_outR", ifb.outR, tblb[c / 2 - 1]);
            cyc();
        end
        ifb.in_valid = 1'b0;

        // 4. Overflow with pole 1.0 and x=127: saturate vs wrap.
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                ifc.in_valid = 1'b1; ifc.inR = 8'sd127;
                ifd.in_valid = 1'b1; ifd.inR = 8'sd127;
            end else begin
                ifc.in_valid = 1'b0;
                ifd.in_valid = 1'b0;
            end
            cyc();
            if (k >= 1) begin
                chk("ovf_sat_valid", ifc.out_valid, 1);
                chk("ovf_sat_outR", ifc.outR, 127);
                chk("ovf_wrap_valid", ifd.out_valid, 1);
                chk("ovf_wrap_outR", ifd.outR, expd[k - 1]);
            end
        end

        // 5. Preload and floor rounding on instance a (in_ch is back at 0).
        chk("pre_in_ch", ifa.in_ch, 0);
        send_a(8'sd0, 8'sd0, 1'b1, 8'sd32, 8'sd0);
        chk("pre_valid", ifa.out_valid, 1);
        chk("pre_outR", ifa.outR, 16);
        chk("pre_outI", ifa.outI, 0);
        send_a(8'sd0, 8'sd0, 1'b1, 8'sd0, 8'sd0);
        chk("pre_ch1_outR", ifa.outR, 0);
        chk("pre_ch1_outI", ifa.outI, 0);
        send_a(8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0);
        chk("pre_next_outR", ifa.outR, 8);
        send_a(8'sd0, 8'sd0, 1'b1, 8'sd0, 8'sd0);
        send_a(8'sd0, 8'sd0, 1'b1, -8'sd1, 8'sd0);
        chk("floor_outR", ifa.outR, -1);
        chk("floor_outI", ifa.outI, 0);
        send_a(8'sd0, 8'sd0, 1'b1, 8'sd0, 8'sd0);
        chk("clr_pre_in_ch", ifa.in_ch, 0);

        // 6. Clear after two accepted samples (ch0 state is -1 going in).
        ifa.in_valid = 1'b1; ifa.inR = 8'sd20; ifa.inI = 8'sd0;
        cyc();
        ifa.inR = 8'sd7;
        cyc();
        chk("clr_first_outR", ifa.outR, 19);
        ifa.in_valid = 1'b0;
        clr_a = 1'b1;
        #1;
        chk("clr_in_ready", ifa.in_ready, 0);
        cyc();
        clr_a = 1'b0;
        chk("clr_out_valid", ifa.out_valid, 0);
        chk("clr_in_ch", ifa.in_ch, 0);
        chk("clr_outR_hold", ifa.outR, 19);
        cyc();
        chk("clr_no_late_valid", ifa.out_valid, 0);
        cyc();
        chk("clr_no_late_valid2", ifa.out_valid, 0);
        send_a(8'sd5, 8'sd0, 1'b0, 8'sd0, 8'sd0);
        chk("clr_after_valid", ifa.out_valid, 1);
        chk("clr_after_ch", ifa.out_ch, 0);
        chk("clr_after_outR", ifa.outR, 5);
        chk("clr_after_outI", ifa.outI, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
